// File: rtl/exe_pkg.sv
// Shared execute-side definitions: ALU opcodes, datapath defaults, occupancy
// state and opcode legality check.
package exe_pkg;

    localparam int DEF_XLEN = 32;
    localparam int DEF_RA_W = 5;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_AND  = 3'd2;
    localparam logic [2:0] ALU_OR   = 3'd3;
    localparam logic [2:0] ALU_XOR  = 3'd4;
    localparam logic [2:0] ALU_MUL  = 3'd5;
    localparam logic [2:0] ALU_MULH = 3'd6;

    typedef enum logic {
        OCC_EMPTY = 1'b0,
        OCC_FULL  = 1'b1
    } occ_e;

    function automatic logic is_legal_aluop(input logic [2:0] op);
        return op != 3'd7;
    endfunction

endpackage

// File: rtl/fwd_sel.sv
// Operand bypass select: MEM result beats WB result beats the base value;
// register x0 is hardwired and never takes a bypass.
module fwd_sel #(
    parameter int XLEN = exe_pkg::DEF_XLEN,
    parameter int RA_W = exe_pkg::DEF_RA_W
) (
    input  logic [RA_W-1:0] i_rs,
    input  logic [XLEN-1:0] i_base,
    input  logic            i_mem_we,
    input  logic [RA_W-1:0] i_mem_rd,
    input  logic [XLEN-1:0] i_mem_data,
    input  logic            i_wb_we,
    input  logic [RA_W-1:0] i_wb_rd,
    input  logic [XLEN-1:0] i_wb_data,
    output logic [XLEN-1:0] o_val
);

    logic w_nonzero;
    assign w_nonzero = (i_rs != '0);

    always_comb begin
        o_val = i_base;
        if (w_nonzero && i_mem_we && (i_mem_rd == i_rs))
            o_val = i_mem_data;
        else if (w_nonzero && i_wb_we && (i_wb_rd == i_rs))
            o_val = i_wb_data;
    end

endmodule

// File: rtl/id_ex_stage.sv
// Single-entry ID/EX register feeding the execute ALU, with MEM/WB operand
// bypass at capture and on the held entry, plus writeback refresh under stall.
//
// state     | meaning
// OCC_EMPTY | no instruction held, out_valid=0
// OCC_FULL  | one instruction held and presented to execute
module id_ex_stage
    import exe_pkg::*;
#(
    parameter int XLEN = DEF_XLEN,
    parameter int RA_W = DEF_RA_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1_val,
    input  logic [XLEN-1:0] in_rs2_val,
    input  logic [XLEN-1:0] in_imm,
    input  logic [RA_W-1:0] in_rs1,
    input  logic [RA_W-1:0] in_rs2,
    input  logic [RA_W-1:0] in_rd,
    input  logic [2:0]      in_alu_op,
    input  logic            in_use_imm,
    input  logic            in_use_pc,
    input  logic            in_reg_we,
    input  logic            mem_we,
    input  logic [RA_W-1:0] mem_rd,
    input  logic [XLEN-1:0] mem_data,
    input  logic            wb_we,
    input  logic [RA_W-1:0] wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [2:0]      alu_op,
    output logic [RA_W-1:0] out_rd,
    output logic            out_reg_we,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_store_data,
    output logic            out_illegal,
    output logic [31:0]     stall_cnt
);

    occ_e            r_state;
    occ_e            w_state_nxt;
    logic [XLEN-1:0] r_pc, r_rs1_val, r_rs2_val, r_imm;
    logic [RA_W-1:0] r_rs1, r_rs2, r_rd;
    logic [2:0]      r_alu_op;
    logic            r_use_imm, r_use_pc, r_reg_we, r_illegal;
    logic [31:0]     r_stall_cnt;

    logic            w_full, w_cap, w_leave, w_legal;
    logic            w_rs1_wb_hit, w_rs2_wb_hit;
    logic [XLEN-1:0] w_cap_rs1, w_cap_rs2, w_fwd_rs1, w_fwd_rs2;

    assign w_full   = (r_state == OCC_FULL);
    assign in_ready = !w_full || out_ready;
    assign w_cap    = in_valid && in_ready && !flush;
    assign w_leave  = w_full && out_ready;
    assign w_legal  = is_legal_aluop(in_alu_op);

    // Capture-path bypass for the incoming instruction.
    fwd_sel #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_cap_rs1 (
        .i_rs(in_rs1), .i_base(in_rs1_val),
        .i_mem_we(mem_we), .i_mem_rd(mem_rd), .i_mem_data(mem_data),
        .i_wb_we(wb_we), .i_wb_rd(wb_rd), .i_wb_data(wb_data),
        .o_val(w_cap_rs1)
    );

    fwd_sel #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_cap_rs2 (
        .i_rs(in_rs2), .i_base(in_rs2_val),
        .i_mem_we(mem_we), .i_mem_rd(mem_rd), .i_mem_data(mem_data),
        .i_wb_we(wb_we), .i_wb_rd(wb_rd), .i_wb_data(wb_data),
        .o_val(w_cap_rs2)
    );

    // Output-path bypass of the held operands.
    fwd_sel #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_out_rs1 (
        .i_rs(r_rs1), .i_base(r_rs1_val),
        .i_mem_we(mem_we), .i_mem_rd(mem_rd), .i_mem_data(mem_data),
        .i_wb_we(wb_we), .i_wb_rd(wb_rd), .i_wb_data(wb_data),
        .o_val(w_fwd_rs1)
    );

    fwd_sel #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_out_rs2 (
        .i_rs(r_rs2), .i_base(r_rs2_val),
        .i_mem_we(mem_we), .i_mem_rd(mem_rd), .i_mem_data(mem_data),
        .i_wb_we(wb_we), .i_wb_rd(wb_rd), .i_wb_data(wb_data),
        .o_val(w_fwd_rs2)
    );

    assign w_rs1_wb_hit = wb_we && (wb_rd == r_rs1) && (r_rs1 != '0);
    assign w_rs2_wb_hit = wb_we && (wb_rd == r_rs2) && (r_rs2 != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= OCC_EMPTY;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush)        w_state_nxt = OCC_EMPTY;
        else if (w_cap)   w_state_nxt = OCC_FULL;
        else if (w_leave) w_state_nxt = OCC_EMPTY;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc        <= '0;
            r_rs1_val   <= '0;
            r_rs2_val   <= '0;
            r_imm       <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_rd        <= '0;
            r_alu_op    <= ALU_ADD;
            r_use_imm   <= 1'b0;
            r_use_pc    <= 1'b0;
            r_reg_we    <= 1'b0;
            r_illegal   <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            if (w_cap) begin
                r_pc      <= in_pc;
                r_rs1_val <= w_cap_rs1;
                r_rs2_val <= w_cap_rs2;
                r_imm     <= in_imm;
                r_rs1     <= in_rs1;
                r_rs2     <= in_rs2;
                r_rd      <= in_rd;
                r_alu_op  <= w_legal ? in_alu_op : ALU_ADD;
                r_use_imm <= in_use_imm;
                r_use_pc  <= in_use_pc;
                r_reg_we  <= in_reg_we && w_legal;
                r_illegal <= !w_legal;
            end else begin
                if (flush) r_illegal <= 1'b0;
                // A producer retiring while we hold must not be lost.
                if (w_full && w_rs1_wb_hit) r_rs1_val <= wb_data;
                if (w_full && w_rs2_wb_hit) r_rs2_val <= wb_data;
            end
            if (w_full && !out_ready && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign out_valid      = w_full;
    assign alu_a          = r_use_pc  ? r_pc  : w_fwd_rs1;
    assign alu_b          = r_use_imm ? r_imm : w_fwd_rs2;
    assign out_store_data = w_fwd_rs2;
    assign alu_op         = r_alu_op;
    assign out_rd         = r_rd;
    assign out_reg_we     = r_reg_we && w_full;
    assign out_pc         = r_pc;
    assign out_illegal    = r_illegal && w_full;
    assign stall_cnt      = r_stall_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, streaming, bypass priority, stall
// refresh, flush collisions and illegal-op handling.
module tb_id_ex_stage;
    import exe_pkg::*;

    logic        clk, rst_n, flush;
    logic        in_valid, in_ready;
    logic [31:0] in_pc, in_rs1_val, in_rs2_val, in_imm;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic [2:0]  in_alu_op;
    logic        in_use_imm, in_use_pc, in_reg_we;
    logic        mem_we, wb_we;
    logic [4:0]  mem_rd, wb_rd;
    logic [31:0] mem_data, wb_data;
    logic        out_valid, out_ready;
    logic [31:0] alu_a, alu_b, out_pc, out_store_data, stall_cnt;
    logic [2:0]  alu_op;
    logic [4:0]  out_rd;
    logic        out_reg_we, out_illegal;

    int n_checks = 0;
    int n_errors = 0;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_alu_op(in_alu_op),
        .in_use_imm(in_use_imm), .in_use_pc(in_use_pc), .in_reg_we(in_reg_we),
        .mem_we(mem_we), .mem_rd(mem_rd), .mem_data(mem_data),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .out_rd(out_rd), .out_reg_we(out_reg_we), .out_pc(out_pc),
        .out_store_data(out_store_data), .out_illegal(out_illegal),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic [4:0] rs1, input logic [31:0] rs1_val,
                          input logic [4:0] rs2, input logic [31:0] rs2_val,
                          input logic [31:0] imm, input logic [31:0] pc,
                          input logic [4:0] rd, input logic [2:0] op,
                          input logic use_imm, input logic use_pc, input logic reg_we);
        in_rs1 = rs1; in_rs1_val = rs1_val;
        in_rs2 = rs2; in_rs2_val = rs2_val;
        in_imm = imm; in_pc = pc; in_rd = rd; in_alu_op = op;
        in_use_imm = use_imm; in_use_pc = use_pc; in_reg_we = reg_we;
    endtask

    initial begin
        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, ALU_ADD, 0, 0, 0);
        mem_we = 1'b0; mem_rd = '0; mem_data = '0;
        wb_we = 1'b0; wb_rd = '0; wb_data = '0;

        // Asynchronous reset asserted mid-cycle
        #3 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_reg_we", out_reg_we, 0);
        chk("rst_out_illegal", out_illegal, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        chk("idle_out_valid", out_valid, 0);

        // Back-to-back adds, no bubbles
        set_in(1, 5, 2, 0, 7, 0, 3, ALU_ADD, 1, 0, 1);
        in_valid = 1'b1;
        tick();
        chk("b2b0_valid", out_valid, 1);
        chk("b2b0_alu_a", alu_a, 5);
        chk("b2b0_alu_b", alu_b, 7);
        chk("b2b0_alu_op", alu_op, 0);
        set_in(1, 6, 2, 0, 8, 0, 3, ALU_ADD, 1, 0, 1);
        tick();
        chk("b2b1_valid", out_valid, 1);
        chk("b2b1_alu_a", alu_a, 6);
        chk("b2b1_alu_b", alu_b, 8);
        set_in(1, 7, 2, 0, 9, 0, 3, ALU_ADD, 1, 0, 1);
        tick();
        chk("b2b2_valid", out_valid, 1);
        chk("b2b2_alu_a", alu_a, 7);
        chk("b2b2_alu_b", alu_b, 9);
        in_valid = 1'b0;
        tick();
        chk("b2b_drain_valid", out_valid, 0);

        // Bypass priority on the held entry
        set_in(3, 1, 4, 9, 0, 0, 5, ALU_ADD, 0, 0, 1);
        in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        chk("byp_nofwd_a", alu_a, 1);
        mem_we = 1'b1; mem_rd = 5'd3; mem_data = 32'd10;
        wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'd20;
        #1;
        chk("byp_mem_over_wb", alu_a, 10);
        chk("byp_in_ready", in_ready, 0);
        mem_we = 1'b0;
        #1;
        chk("byp_wb_only", alu_a, 20);
        wb_we = 1'b0;
        #1;
        chk("byp_none", alu_a, 1);
        out_ready = 1'b1;
        tick();
        chk("byp_leave_valid", out_valid, 0);

        // x0 never matches a bypass
        set_in(0, 1, 4, 9, 0, 0, 5, ALU_ADD, 0, 0, 1);
        mem_we = 1'b1; mem_rd = 5'd0; mem_data = 32'd10;
        wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'd20;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("x0_alu_a", alu_a, 1);
        mem_we = 1'b0; wb_we = 1'b0;
        tick();
        chk("x0_leave_valid", out_valid, 0);

        // Stall with writeback refresh of held rs2
        set_in(1, 0, 2, 32'h11, 0, 0, 6, ALU_OR, 0, 0, 1);
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
        set_in(1, 0, 2, 32'h99, 0, 0, 6, ALU_ADD, 0, 0, 1);
        out_ready = 1'b0;
        #1;
        chk("stall_in_ready", in_ready, 0);
        tick();
        wb_we = 1'b1; wb_rd = 5'd2; wb_data = 32'h55;
        tick();
        wb_we = 1'b0;
        tick();
        tick();
        chk("stall_cnt4", stall_cnt, 4);
        chk("stall_valid", out_valid, 1);
        chk("stall_alu_op", alu_op, 3);
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        chk("refresh_alu_b", alu_b, 32'h55);
        chk("refresh_store", out_store_data, 32'h55);
        chk("stall_release_in_ready", in_ready, 1);
        tick();
        chk("stall_leave_valid", out_valid, 0);
        chk("stall_cnt_hold", stall_cnt, 4);

        // Illegal op, then flush while stalled with input present
        set_in(1, 3, 2, 4, 0, 0, 9, 3'd7, 0, 0, 1);
        in_valid = 1'b1; out_ready = 1'b0;
        tick();
        chk("ill_alu_op", alu_op, 0);
        chk("ill_flag", out_illegal, 1);
        chk("ill_reg_we", out_reg_we, 0);
        chk("ill_valid", out_valid, 1);
        set_in(1, 32'h77, 2, 4, 0, 0, 9, ALU_ADD, 0, 0, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_valid", out_valid, 0);
        chk("flush_illegal", out_illegal, 0);
        tick();
        chk("flush_no_capture", out_valid, 0);

        // Capture-time WB bypass, use_pc path, then flush with out_ready=1
        set_in(1, 0, 5, 1, 0, 32'h100, 7, ALU_MUL, 0, 1, 1);
        wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'hAB;
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
        wb_we = 1'b0; in_valid = 1'b0;
        #1;
        chk("pc_alu_a", alu_a, 32'h100);
        chk("mul_alu_op", alu_op, 5);
        chk("cap_wb_store", out_store_data, 32'hAB);
        chk("cap_reg_we", out_reg_we, 1);
        chk("cap_rd", out_rd, 7);
        chk("cap_pc", out_pc, 32'h100);
        set_in(1, 32'h33, 2, 0, 0, 0, 8, ALU_ADD, 0, 0, 1);
        in_valid = 1'b1; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_rdy_valid", out_valid, 0);
        tick();
        chk("flush_rdy_no_capture", out_valid, 0);
        chk("stall_cnt_total", stall_cnt, 5);

        // Reset while holding an entry
        set_in(1, 2, 2, 3, 0, 0, 4, ALU_ADD, 0, 0, 1);
        in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        chk("pre_rst_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_stall_cnt", stall_cnt, 0);
        chk("midrst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
